// File: rtl/picorv32_trace_pkg.sv
// Shared constants for the picorv32 trace buffer: widths, register map, CTRL bits.
package picorv32_trace_pkg;

  localparam int unsigned TRACE_W  = 36;
  localparam int unsigned TSTAMP_W = 32;

  // Byte offsets of the Wishbone registers; bits [4:2] select the register.
  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_COUNT   = 5'h04;
  localparam logic [4:0] OFF_DATA_LO = 5'h08;
  localparam logic [4:0] OFF_DATA_HI = 5'h0C;
  localparam logic [4:0] OFF_TSTAMP  = 5'h10;

  // CTRL bit positions.
  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_WRAP     = 1;
  localparam int unsigned CTRL_CLEAR    = 2;
  localparam int unsigned CTRL_FROZEN   = 3;
  localparam int unsigned CTRL_OVERFLOW = 4;

endpackage

// File: rtl/trace_buf_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// A write to the address being read in the same cycle is forwarded, so the
// registered head always reflects the newest contents.
module trace_buf_ram
  import picorv32_trace_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = TRACE_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Write port plus write-first registered read port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (we_i && (waddr_i == raddr_i)) rdata_o <= wdata_i;
    else                              rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/picorv32_trace_buffer.sv
// Circular capture buffer for the picorv32 trace port with a Wishbone classic
// slave. Capture freezes on a rising trap edge until software writes CLEAR.
// Optional feature: define TRACE_TIMESTAMP_EN to store a 32-bit cycle stamp
// with each entry, readable at TSTAMP.
module picorv32_trace_buffer
  import picorv32_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               trace_valid_i,
  input  logic [TRACE_W-1:0] trace_data_i,
  input  logic               trap_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               irq_o
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = TRACE_W + TSTAMP_W;
`else
  localparam int unsigned ENTRY_W = TRACE_W;
`endif
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [2:0] SEL_CTRL    = OFF_CTRL[4:2];
  localparam logic [2:0] SEL_COUNT   = OFF_COUNT[4:2];
  localparam logic [2:0] SEL_DATA_LO = OFF_DATA_LO[4:2];
  localparam logic [2:0] SEL_DATA_HI = OFF_DATA_HI[4:2];
  localparam logic [2:0] SEL_TSTAMP  = OFF_TSTAMP[4:2];

  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic enable_q, enable_d, wrap_q, wrap_d;
  logic frozen_q, frozen_d, overflow_q, overflow_d;
  logic trap_q, ack_q, irq_q;
  logic [31:0] dat_q, dat_d;

  logic req, empty, full, clear, pop, capture, ram_we;
  logic [2:0] reg_sel;
  logic [ENTRY_W-1:0] ram_wdata, head;
  logic unused_bits;

  // A new access is only accepted when no ack is in flight.
  assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign reg_sel = wb_adr_i[4:2];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign clear   = req & wb_we_i & (reg_sel == SEL_CTRL) & wb_dat_i[CTRL_CLEAR];
  assign pop     = req & ~wb_we_i & (reg_sel == SEL_DATA_HI) & ~empty;
  assign capture = enable_q & ~frozen_q & trace_valid_i & ~clear;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:3]};

`ifdef TRACE_TIMESTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_q;

  // Free-running cycle counter stored alongside each captured word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tstamp_q <= '0;
    else          tstamp_q <= tstamp_q + 1'b1;
  end

  assign ram_wdata = {tstamp_q, trace_data_i};
`else
  assign ram_wdata = trace_data_i;
`endif

  // Read address follows the next read pointer so the head is pre-read.
  trace_buf_ram #(
    .ADDR_W(DEPTH_LOG2),
    .DATA_W(ENTRY_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(ram_wdata),
    .raddr_i(rd_ptr_d),
    .rdata_o(head)
  );

  // Buffer bookkeeping: control writes, capture, pop, freeze and clear.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    enable_d   = enable_q;
    wrap_d     = wrap_q;
    frozen_d   = frozen_q;
    overflow_d = overflow_q;
    ram_we     = 1'b0;

    if (req && wb_we_i && (reg_sel == SEL_CTRL)) begin
      enable_d = wb_dat_i[CTRL_ENABLE];
      wrap_d   = wb_dat_i[CTRL_WRAP];
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (capture) begin
      // A same-cycle pop frees a slot first, so a full buffer still accepts.
      if (!full || pop) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!pop) count_d = count_q + 1'b1;
      end else if (wrap_q) begin
        ram_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        overflow_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop) begin
      count_d = count_q - 1'b1;
    end

    if (enable_q && trap_i && !trap_q) frozen_d = 1'b1;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      frozen_d   = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // Read mux, sampled into the ack-cycle data register.
  always_comb begin
    dat_d = '0;
    if (req && !wb_we_i) begin
      case (reg_sel)
        SEL_CTRL: begin
          dat_d[CTRL_ENABLE]   = enable_q;
          dat_d[CTRL_WRAP]     = wrap_q;
          dat_d[CTRL_FROZEN]   = frozen_q;
          dat_d[CTRL_OVERFLOW] = overflow_q;
        end
        SEL_COUNT:   dat_d = 32'(count_q);
        SEL_DATA_LO: if (!empty) dat_d = head[31:0];
        SEL_DATA_HI: if (!empty) dat_d = {28'b0, head[TRACE_W-1:32]};
`ifdef TRACE_TIMESTAMP_EN
        SEL_TSTAMP:  if (!empty) dat_d = head[ENTRY_W-1:TRACE_W];
`else
        SEL_TSTAMP:  dat_d = '0;
`endif
        default:     dat_d = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      enable_q   <= 1'b0;
      wrap_q     <= 1'b0;
      frozen_q   <= 1'b0;
      overflow_q <= 1'b0;
      trap_q     <= 1'b0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      enable_q   <= enable_d;
      wrap_q     <= wrap_d;
      frozen_q   <= frozen_d;
      overflow_q <= overflow_d;
      trap_q     <= trap_i;
      ack_q      <= req;
      irq_q      <= frozen_q | overflow_q;
      dat_q      <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_picorv32_trace_buffer.sv
// Directed bench for picorv32_trace_buffer with a 4-entry buffer.
module tb_picorv32_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trace_valid;
  logic [35:0] trace_data;
  logic        trap;
  logic        wb_cyc, wb_stb, wb_we;
  logic [4:0]  wb_adr;
  logic [31:0] wb_wdat, wb_rdat;
  logic        wb_ack, irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  picorv32_trace_buffer #(.DEPTH_LOG2(2)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .trace_valid_i(trace_valid),
    .trace_data_i (trace_data),
    .trap_i       (trap),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_we_i      (wb_we),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_wdat),
    .wb_dat_o     (wb_rdat),
    .wb_ack_o     (wb_ack),
    .irq_o        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [4:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
    int n = 0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_wdat = wd;
    @(posedge clk); #1;
    while (!wb_ack && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 8) check("ack_timeout", 32'(wb_ack), 32'd1);
    rd = wb_rdat;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(1'b0, a, 32'd0, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] d;
    wb_access(1'b1, a, wd, d);
  endtask

  task automatic inject(input logic [35:0] w);
    trace_valid = 1'b1; trace_data = w;
    @(posedge clk); #1;
    trace_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; trace_valid = 1'b0; trace_data = '0; trap = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_dat", wb_rdat, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_ctrl", 5'h00, 32'h0);
    rd_chk("rst_count", 5'h04, 32'h0);

    // Stop-when-full: fifth word dropped, overflow set.
    wr(5'h00, 32'h1);
    for (int i = 1; i <= 5; i++) inject(36'h1_0000_0000 + 36'(i));
    rd_chk("nowrap_count", 5'h04, 32'd4);
    rd_chk("nowrap_ctrl", 5'h00, 32'h11);
    check("nowrap_irq", 32'(irq), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      rd_chk("nowrap_lo", 5'h08, 32'(i));
      rd_chk("nowrap_hi", 5'h0C, 32'h1);
    end
    rd_chk("nowrap_count_end", 5'h04, 32'd0);
    rd_chk("unmapped", 5'h14, 32'h0);

    // Overwrite-oldest: clear, then words 2..5 survive.
    wr(5'h00, 32'h7);
    rd_chk("clr_ctrl", 5'h00, 32'h03);
    check("clr_irq", 32'(irq), 32'd0);
    for (int i = 1; i <= 5; i++) inject(36'h1_0000_0000 + 36'(i));
    rd_chk("wrap_count", 5'h04, 32'd4);
    rd_chk("wrap_ctrl", 5'h00, 32'h13);
    for (int i = 2; i <= 5; i++) begin
      rd_chk("wrap_lo", 5'h08, 32'(i));
      rd_chk("wrap_hi", 5'h0C, 32'h1);
    end
    rd_chk("wrap_count_end", 5'h04, 32'd0);
    check("wrap_irq_held", 32'(irq), 32'd1);
    wr(5'h00, 32'h7);
    rd_chk("wrap_clr_ctrl", 5'h00, 32'h03);
    check("wrap_clr_irq", 32'(irq), 32'd0);

    // Full with wrap: pop and capture in the same cycle.
    for (int i = 0; i < 4; i++) inject(36'h2_0000_0010 + 36'(i));
    trace_valid = 1'b1; trace_data = 36'h2_0000_0014;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 5'h0C;
    @(posedge clk); #1;
    trace_valid = 1'b0;
    check("popcap_ack", 32'(wb_ack), 32'd1);
    check("popcap_hi", wb_rdat, 32'h2);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    rd_chk("popcap_count", 5'h04, 32'd4);
    rd_chk("popcap_ctrl", 5'h00, 32'h03);
    for (int i = 1; i <= 4; i++) begin
      rd_chk("popcap_lo", 5'h08, 32'h10 + 32'(i));
      rd_chk("popcap_hi2", 5'h0C, 32'h2);
    end

    // Freeze: word with the trap edge kept, following word dropped.
    trap = 1'b1; trace_valid = 1'b1; trace_data = 36'hA;
    @(posedge clk); #1;
    trace_data = 36'hB;
    @(posedge clk); #1;
    trace_valid = 1'b0; trap = 1'b0;
    rd_chk("frz_count", 5'h04, 32'd1);
    rd_chk("frz_ctrl", 5'h00, 32'h0B);
    rd_chk("frz_lo", 5'h08, 32'hA);
    check("frz_irq", 32'(irq), 32'd1);
`ifndef TRACE_TIMESTAMP_EN
    rd_chk("tstamp_off", 5'h10, 32'h0);
`endif
    wr(5'h00, 32'h7);
    rd_chk("frz_clr_ctrl", 5'h00, 32'h03);
    rd_chk("frz_clr_count", 5'h04, 32'd0);

    // Empty DATA_HI read with stb held through the ack cycle.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 5'h0C;
    @(posedge clk); #1;
    check("empty_ack", 32'(wb_ack), 32'd1);
    check("empty_hi", wb_rdat, 32'h0);
    @(posedge clk); #1;
    check("empty_ack_once", 32'(wb_ack), 32'd0);
    check("empty_dat_idle", wb_rdat, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    rd_chk("empty_count", 5'h04, 32'd0);

`ifdef TRACE_TIMESTAMP_EN
    begin
      logic [31:0] t1, t2;
      inject(36'h21);
      repeat (6) @(posedge clk);
      #1;
      inject(36'h22);
      wb_access(1'b0, 5'h10, 32'd0, t1);
      rd_chk("ts_pop", 5'h0C, 32'h0);
      wb_access(1'b0, 5'h10, 32'd0, t2);
      check("ts_delta", t2 - t1, 32'd7);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
